// File: rtl/mm_mem_pkg.sv
// Shared constants and types for the matrix-multiply memory read path.
// Holds the block-RAM read latencies and the stream reader state encoding.
package mm_mem_pkg;

  localparam int READ_LAT_HIGH_PERF = 2;
  localparam int READ_LAT_LOW_LAT   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } reader_state_e;

  // Read latency of the RAM for the selected output-register mode.
  function automatic int read_lat_for(input bit high_perf);
    return high_perf ? READ_LAT_HIGH_PERF : READ_LAT_LOW_LAT;
  endfunction

  // Address width for a RAM of the given depth, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mm_fwft_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// dout shows the head entry whenever empty=0; storage clears on reset so
// the head reads as zero until the first write.
module mm_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full, push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  // Storage, pointers and occupancy; push and pop may both happen in a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din;
        wr_q        <= (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/sdp_ram_stream_reader.sv
// Sequential reader for the read port of a simple-dual-port block RAM.
// Issues one read per cycle while output buffer credit allows, tracks reads
// in flight with a valid pipe matching the RAM latency, and streams returned
// words out over valid/ready with a last marker.
// Optional: define SDP_READER_PERF_EN to add the stall_cycles counter port.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing reads, gated by output buffer credit
// DRAIN | all reads issued, waiting for the last beat to handshake
// FIN   | one-cycle done pulse
module sdp_ram_stream_reader
  import mm_mem_pkg::*;
#(
  parameter int RAM_WIDTH    = 36,
  parameter int RAM_DEPTH    = 512,
  parameter int READ_LATENCY = read_lat_for(1'b1),
  parameter int FIFO_DEPTH   = 4,
  localparam int ADDR_W      = addr_width(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    ram_addrb,
  output logic                 ram_enb,
  output logic                 ram_regceb,
  output logic                 ram_rstb,
  input  logic [RAM_WIDTH-1:0] ram_doutb,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_last
`ifdef SDP_READER_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IFL_W = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  reader_state_e           state_q;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        rem_q;
  logic                    busy_q, done_q;
  logic [READ_LATENCY-1:0] vld_q, last_q;
  logic [IFL_W-1:0]        inflight;
  logic [CNT_W-1:0]        fifo_count;
  logic [31:0]             credit;
  logic                    issue, is_last_issue, push, pop, fifo_empty, drain_ok;
  logic [RAM_WIDTH:0]      fifo_dout;

  // Explicit compare so non-power-of-two depths wrap at RAM_DEPTH-1.
  assign addr_d        = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  assign is_last_issue = (rem_q == LEN_W'(1));
  assign pop           = m_valid && m_ready;
  // A pop this cycle frees a slot, keeping one beat per cycle sustainable.
  assign credit        = 32'(inflight) + 32'(fifo_count) - 32'(pop);
  assign issue         = (state_q == ISSUE) && (credit < 32'(FIFO_DEPTH));
  assign drain_ok      = (vld_q == '0) &&
                         (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

  // Count of reads travelling through the RAM output pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight += IFL_W'(vld_q[i]);
  end

  // Job sequencing, address generation and registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= base_addr;
              rem_q   <= len;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q <= addr_d;
            rem_q  <= rem_q - 1'b1;
            if (is_last_issue) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid/last pipe marking the cycle each read's data appears on ram_doutb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q[0]  <= issue;
      last_q[0] <= issue && is_last_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign push = vld_q[READ_LATENCY-1];

  mm_fwft_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({last_q[READ_LATENCY-1], ram_doutb}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_dout[RAM_WIDTH-1:0];
  assign m_last     = m_valid && fifo_dout[RAM_WIDTH];
  assign ram_enb    = issue;
  assign ram_addrb  = addr_q;
  assign ram_regceb = 1'b1;
  assign ram_rstb   = 1'b0;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef SDP_READER_PERF_EN
  logic [31:0] stall_q;

  // Backpressure stall counter; restarts with each job and saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (busy_q && m_valid && !m_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sdp_ram_stream_reader.sv
// Self-checking bench for sdp_ram_stream_reader with a 2-cycle RAM model.
// Honors SDP_READER_PERF_EN to exercise the stall counter.
module tb_sdp_ram_stream_reader;

  localparam int DEPTH = 512;
  localparam int W     = 36;
  localparam int FD    = 4;
  localparam int M_ALW = 0;
  localparam int M_TOG = 1;
  localparam int M_RND = 2;

  typedef struct {
    int          base;
    int          n;
    int          mode;
    bit          poke;
    logic [35:0] exp_first;
    logic [35:0] exp_last;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [8:0]    base_addr;
  logic [9:0]    len;
  logic          busy, done, ram_enb, ram_regceb, ram_rstb;
  logic [8:0]    ram_addrb;
  logic [W-1:0]  ram_doutb;
  logic          m_valid, m_ready, m_last;
  logic [W-1:0]  m_data;
`ifdef SDP_READER_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  sdp_ram_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .ram_addrb  (ram_addrb),
    .ram_enb    (ram_enb),
    .ram_regceb (ram_regceb),
    .ram_rstb   (ram_rstb),
    .ram_doutb  (ram_doutb),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
`ifdef SDP_READER_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // RAM model: word[i] = i, output register stage enabled by regceb.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] ram_s1, ram_s2;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
  always @(posedge clk) begin
    if (ram_enb) ram_s1 <= mem[ram_addrb];
    if (ram_regceb) ram_s2 <= ram_s1;
  end
  assign ram_doutb = ram_s2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  logic [8:0]  exp_addr [$];
  logic [36:0] exp_beat [$];
  int issued, popped, first_hs, last_hs, hs_cnt, done_cyc;
  logic [35:0] first_word, last_word, prev_data;
  logic prev_stall, prev_last, prev_done, done_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      M_ALW:   return 1'b1;
      M_TOG:   return (k >= 14 && k < 24) ? 1'b0 : logic'(k % 2 == 0);
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    logic [36:0] e;
    logic [8:0]  a;
    prev_stall = 0; prev_done = 0; prev_last = 0; prev_data = '0;
    issued = 0; popped = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0; prev_done = 0; issued = 0; popped = 0;
      end else begin
        if (ram_enb) begin
          issued++;
          if (exp_addr.size() == 0) fail("spurious_enb");
          else begin
            a = exp_addr.pop_front();
            chk("ram_addrb", 64'(ram_addrb), 64'(a));
          end
        end
        if (prev_stall) begin
          chk("hold_valid", 64'(m_valid), 64'd1);
          chk("hold_data", 64'(m_data), 64'(prev_data));
          chk("hold_last", 64'(m_last), 64'(prev_last));
        end
        if (m_valid && m_ready) begin
          popped++;
          hs_cnt++;
          if (first_hs < 0) begin first_hs = cyc; first_word = m_data; end
          if (m_last) begin last_hs = cyc; last_word = m_data; end
          if (exp_beat.size() == 0) fail("spurious_beat");
          else begin
            e = exp_beat.pop_front();
            chk("m_data", 64'(m_data), 64'(e[35:0]));
            chk("m_last", 64'(m_last), 64'(e[36]));
          end
        end
        if (busy) chk("credit", 64'((issued - popped) <= FD), 64'd1);
        if (done) begin
          if (prev_done) fail("done_width");
          done_cyc  = cyc;
          done_busy = busy;
        end
        prev_done  = done;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic push_job(input int b, input int n);
    int a;
    logic lst;
    for (int i = 0; i < n; i++) begin
      a   = (b + i) % DEPTH;
      lst = (i == n - 1);
      exp_addr.push_back(9'(a));
      exp_beat.push_back({lst, 36'(a)});
    end
    first_hs = -1; last_hs = -1; hs_cnt = 0; done_cyc = -1;
  endtask

  task automatic run_job(input vec_t v);
    int s, k;
    @(posedge clk); #1;
    push_job(v.base, v.n);
    start = 1'b1; base_addr = 9'(v.base); len = 10'(v.n);
    s = cyc; k = 0;
    m_ready = ready_for(v.mode, k);
    while (done_cyc < 0 && k < 2000) begin
      @(posedge clk); #1;
      k++;
      start = v.poke && (k == 3);
      if (start) begin base_addr = 9'd0; len = 10'd3; end
      m_ready = ready_for(v.mode, k);
    end
    start = 1'b0;
    if (done_cyc < 0) fail("done_timeout");
    @(negedge clk);
    chk("busy_clear", 64'(busy), 64'd0);
    chk("busy_at_done", 64'(done_busy), 64'd1);
    chk("beat_count", 64'(hs_cnt), 64'(v.n));
    if (v.n == 0) chk("done_lat_len0", 64'(done_cyc), 64'(s + 1));
    else begin
      chk("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
      chk("first_word", 64'(first_word), 64'(v.exp_first));
      chk("last_word", 64'(last_word), 64'(v.exp_last));
    end
    if (v.mode == M_ALW && v.n > 0) begin
      chk("first_latency", 64'(first_hs), 64'(s + 4));
      chk("throughput", 64'(last_hs - first_hs), 64'(v.n - 1));
    end
    chk("sb_drained", 64'(exp_beat.size() + exp_addr.size()), 64'd0);
  endtask

  vec_t tv [8];

  initial begin
    tv[0] = '{10,  8,   M_ALW, 1'b0, 36'd10,  36'd17};
    tv[1] = '{508, 6,   M_ALW, 1'b0, 36'd508, 36'd1};
    tv[2] = '{0,   0,   M_ALW, 1'b0, 36'd0,   36'd0};
    tv[3] = '{100, 20,  M_TOG, 1'b0, 36'd100, 36'd119};
    tv[4] = '{511, 1,   M_RND, 1'b0, 36'd511, 36'd511};
    tv[5] = '{40,  6,   M_ALW, 1'b1, 36'd40,  36'd45};
    tv[6] = '{0,   512, M_ALW, 1'b0, 36'd0,   36'd511};
    tv[7] = '{300, 7,   M_RND, 1'b0, 36'd300, 36'd306};

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    first_hs = -1; last_hs = -1; hs_cnt = 0; done_cyc = -1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_enb", 64'(ram_enb), 64'd0);
    chk("rst_addrb", 64'(ram_addrb), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("regceb_const", 64'(ram_regceb), 64'd1);
    chk("rstb_const", 64'(ram_rstb), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 8; i++) run_job(tv[i]);

    // Abort a len=16 job three cycles in with an asynchronous reset.
    @(posedge clk); #1;
    push_job(0, 16);
    start = 1'b1; base_addr = 9'd0; len = 10'd16; m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_enb", 64'(ram_enb), 64'd0);
    chk("abort_addrb", 64'(ram_addrb), 64'd0);
    chk("abort_valid", 64'(m_valid), 64'd0);
    chk("abort_last", 64'(m_last), 64'd0);
    chk("abort_data", 64'(m_data), 64'd0);
    exp_addr.delete();
    exp_beat.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run_job('{0, 2, M_ALW, 1'b0, 36'd0, 36'd1});
    repeat (8) @(posedge clk);

`ifdef SDP_READER_PERF_EN
    begin
      int k;
      @(posedge clk); #1;
      push_job(20, 4);
      start = 1'b1; base_addr = 9'd20; len = 10'd4; m_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!m_valid && k < 50) begin @(posedge clk); #1; k++; end
      if (!m_valid) fail("perf_valid_timeout");
      repeat (4) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      m_ready = 1'b1;
      k = 0;
      while (done_cyc < 0 && k < 100) begin @(posedge clk); #1; k++; end
      if (done_cyc < 0) fail("perf_done_timeout");
      chk("stall_cycles", 64'(stall_cycles), 64'd5);
      chk("perf_beats", 64'(hs_cnt), 64'd4);
    end
`endif

    repeat (4) @(posedge clk);
    chk("final_sb_empty", 64'(exp_beat.size() + exp_addr.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdp_ram_stream_reader.md
Name: sdp_ram_stream_reader

Overview:
- Read-side controller that sits directly downstream of the simple-dual-port block RAM in HIGH_PERFORMANCE mode (2-cycle read latency).
- Given a base address and a beat count, it issues sequential reads on the RAM read port and tracks reads in flight.
- Returned words go out as a valid/ready stream to the matrix-multiply datapath; no beat is dropped or duplicated under backpressure.

Parameters:
- RAM_WIDTH, 36, data width; must equal the RAM's RAM_WIDTH.
- RAM_DEPTH, 512, RAM entries; ADDR_W = max(1, ceil(log2(RAM_DEPTH))).
- READ_LATENCY, 2, cycles from enb asserted to doutb valid; 2 for HIGH_PERFORMANCE, 1 for LOW_LATENCY.
- FIFO_DEPTH, 4, output buffer entries; must be >= READ_LATENCY+1 for full throughput.

Ports:
- clk  in  1  single clock; drives both this block and the RAM read port.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- base_addr  in  ADDR_W  first read address.
- len  in  ADDR_W+1  beats to read, 0..RAM_DEPTH.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle pulse when the job completes.
- ram_addrb  out  ADDR_W  RAM read address.
- ram_enb  out  1  RAM read enable; high only on issue cycles.
- ram_regceb  out  1  constant 1.
- ram_rstb  out  1  constant 0.
- ram_doutb  in  RAM_WIDTH  RAM read data.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  RAM_WIDTH  output beat.
- m_last  out  1  marks the final beat of the job.

Behaviour:
- Reset values: busy=0, done=0, ram_enb=0, ram_addrb=0, m_valid=0, m_last=0, m_data=0. Counters, the in-flight pipe and the FIFO are cleared.
- FSM states:
  - IDLE: on start with len!=0, latch addr=base_addr and remaining=len, go to ISSUE. On start with len==0, go to FIN.
  - ISSUE: issue one read per cycle while the credit check passes. On the last issue, go to DRAIN.
  - DRAIN: wait until in-flight=0, FIFO empty and the last beat has handshaked, then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0 on the next cycle, return to IDLE.
- Issue rule: issue when inflight + fifo_count < FIFO_DEPTH, counting the cycle's FIFO pop as freeing a slot. An issue drives ram_enb=1 with ram_addrb=addr, then increments addr and decrements remaining.
- Address wrap: after RAM_DEPTH-1 the next address is 0, for both power-of-two and non-power-of-two depths.
- Return path: a READ_LATENCY-deep valid shift register (valid plus a last tag) marks which cycles carry read data. A tagged cycle pushes ram_doutb into the FIFO in that cycle. The credit check guarantees the FIFO is never full on a push.
- Output: the FIFO is first-word-fall-through; m_valid = !empty.
  - Once m_valid is high, m_data and m_last hold stable until m_ready.
  - A push and a pop in the same cycle are both performed.
  - Minimum latency from the first issue to m_valid is READ_LATENCY+1 cycles (registered FIFO write).
- Throughput: 1 beat/cycle when m_ready is held high.
- start while busy=1 is ignored and has no side effects.
- Mid-job reset: the job aborts immediately. Data already in flight in the RAM pipeline is discarded because the valid pipe clears. No done pulse.

Optional Feature:
- Macro: SDP_READER_PERF_EN.
- Defined: adds output port stall_cycles (32 bits, reset 0).
  - Counts cycles with m_valid=1 and m_ready=0 while busy=1.
  - Clears on an accepted start and saturates at all-ones.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package mm_mem_pkg holds the READ_LAT_HIGH_PERF=2 and READ_LAT_LOW_LAT=1 constants and the reader state enum typedef (IDLE, ISSUE, DRAIN, FIN).
- One sub-module, mm_fwft_fifo: parameterised WIDTH and DEPTH, first-word-fall-through, with count output; it implements the output buffer.

Test Plan:
- base=10, len=8, m_ready=1 with the RAM preloaded word[i]=i → m_data 10..17 on consecutive cycles; m_last on 17; done exactly one cycle after the last handshake.
- base=508, len=6, RAM_DEPTH=512 → addresses 508,509,510,511,0,1 and data in that order.
- len=0 → no ram_enb; done pulses one cycle later; m_valid stays 0.
- len=20 with m_ready toggling 1-0 and then low for 10 cycles → all 20 beats in order, no loss or duplicates; inflight+fifo_count never exceeds 4; m_data stable while stalled.
- Reset asserted 3 cycles into a len=16 job → outputs return to reset values asynchronously; after release, a new start base=0 len=2 returns only words 0,1.
- SDP_READER_PERF_EN defined, len=4, m_ready low for 5 cycles after the first m_valid → stall_cycles=5 at done.
